// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - SRAM-like data-port slave with byte-strobed memory and fixed-latency in-order responses
module data_sram_responder #(
  parameter int ADDR_W   = 12,
  parameter int RESP_LAT = 2,
  parameter int DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        addr_stall,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int CW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CD_INIT = CW'(RESP_LAT - 1);

  logic [31:0]       mem_q [2**ADDR_W];
  logic [CW-1:0]     cd_q  [DEPTH];
  logic [CW-1:0]     cd_d  [DEPTH];
  logic [31:0]       rd_q  [DEPTH];
  logic [31:0]       rd_d  [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]     count_q, count_d;
  logic [31:0]       rdata_q;
  logic [ADDR_W-1:0] idx;
  logic              push, pop;
  logic              unused_bits;

  // size and the byte offset never affect indexing or masking
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};
  assign idx = addr[ADDR_W+1:2];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // No bypass: a full queue refuses even when its head pops this cycle
  assign addr_ok = !reset && !addr_stall && (count_q < NW'(DEPTH));
  assign push    = req && addr_ok;
  assign data_ok = !reset && (count_q != '0) && (cd_q[rd_ptr_q] == '0);
  assign pop     = data_ok;
  assign rdata   = reset ? '0 : (data_ok ? rd_q[rd_ptr_q] : rdata_q);

  always_comb begin
    cd_d     = cd_q;
    rd_d     = rd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cd_q[i] != '0) cd_d[i] = cd_q[i] - CW'(1);
    end
    if (push) begin
      cd_d[wr_ptr_q] = CD_INIT;
      rd_d[wr_ptr_q] = wr ? 32'h0 : mem_q[idx];
      wr_ptr_d       = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata;
    end
  end

  // Entry payloads are only meaningful below count_q, so they need no reset
  always_ff @(posedge clk) begin
    cd_q <= cd_d;
    rd_q <= rd_d;
  end

  always_ff @(posedge clk) begin
    if (push && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule
